// File: rtl/stream_mux_8to1.sv
// 8-to-1 valid/ready stream mux with round-robin arbitration.
// Registered output carries the beat and the index of its source channel.
module stream_mux_8to1 #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      in_valid,
  input  logic [8*DW-1:0] in_data,
  output logic [7:0]      in_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [2:0]      out_sel,
  input  logic            out_ready
);

  logic [2:0] last_grant;
  logic [2:0] grant;
  logic [2:0] idx;
  logic       found;
  logic       load;

  // Scan starts just after the last winner; last_grant itself is checked last.
  always_comb begin
    grant = last_grant;
    found = 1'b0;
    idx   = last_grant;
    for (int k = 1; k <= 8; k++) begin
      idx = last_grant + 3'(k);
      if (!found && in_valid[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  assign load     = rst_n && (!out_valid || out_ready) && (|in_valid);
  assign in_ready = load ? (8'(1) << grant) : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= 3'd0;
      last_grant <= 3'd7;
    end else if (load) begin
      out_valid  <= 1'b1;
      out_data   <= in_data[grant*DW +: DW];
      out_sel    <= grant;
      last_grant <= grant;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule
